// File: rtl/affine_subblock_scheduler_pkg.sv
// Shared types and constants for the affine sub-block scheduler.
package affine_subblock_scheduler_pkg;

    localparam int BLK_STEP_DEF = 4;
    localparam int CNT_W_DEF    = 4;
    localparam int COORD_W      = 8;
    localparam int CPMV_W       = 16;
    localparam int PERF_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_FINISH = 3'd5
    } sched_state_e;

endpackage

// File: rtl/affine_subblock_scheduler_grid_counter.sv
// Raster-order column/row counter over a CU's sub-block grid.
module subblock_grid_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_async_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] w_m1,
    input  logic [CNT_W-1:0] h_m1,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             col_wrap,
    output logic             last
);

    assign col_wrap = (col == w_m1);
    assign last     = col_wrap && (row == h_m1);

    // On the final sub-block the column still wraps to 0 while the row holds.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (!col_wrap) begin
                col <= col + 1'b1;
            end else begin
                col <= '0;
                if (row != h_m1) row <= row + 1'b1;
            end
        end
    end

endmodule

// File: rtl/affine_subblock_scheduler.sv
// Walks every sub-block of an affine CU, driving coord/CPMV and start into the core.
// Optional PERF_CYCLES counter is built when SCHED_PERF_CNT_EN is defined.
module affine_subblock_scheduler
    import affine_subblock_scheduler_pkg::*;
#(
    parameter int BLK_STEP = BLK_STEP_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_async_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [COORD_W-1:0]   req_x0,
    input  logic [COORD_W-1:0]   req_y0,
    input  logic [CNT_W-1:0]     req_w_m1,
    input  logic [CNT_W-1:0]     req_h_m1,
    input  logic [CPMV_W-1:0]    req_cpmv_0,
    input  logic [CPMV_W-1:0]    req_cpmv_1,
    output logic                 core_start,
    output logic [COORD_W-1:0]   core_coord_x,
    output logic [COORD_W-1:0]   core_coord_y,
    output logic [CPMV_W-1:0]    core_cpmv_0,
    output logic [CPMV_W-1:0]    core_cpmv_1,
    input  logic                 core_done_all,
    output logic                 busy,
    output logic                 cu_done,
`ifdef SCHED_PERF_CNT_EN
    output logic [PERF_W-1:0]    perf_cycles,
`endif
    output logic [2*CNT_W-1:0]   sb_idx,
    output logic [2:0]           dbg_state
);

    sched_state_e state_q, state_d;

    logic [COORD_W-1:0] x0_q, y0_q;
    logic [CNT_W-1:0]   w_m1_q, h_m1_q;
    logic [CNT_W-1:0]   col, row;
    logic               col_wrap, grid_last;
    logic               accept;

    // Request handshake: a transfer happens on a rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE, fields are
    // captured on that edge and ignored otherwise.
    assign accept = req_valid && req_ready;

    subblock_grid_counter #(.CNT_W(CNT_W)) u_grid (
        .clk        (clk),
        .rst_async_n(rst_async_n),
        .clear      (accept),
        .advance    (state_q == ST_NEXT),
        .w_m1       (w_m1_q),
        .h_m1       (h_m1_q),
        .col        (col),
        .row        (row),
        .col_wrap   (col_wrap),
        .last       (grid_last)
    );

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_START;
            ST_START:  state_d = ST_WAIT;
            ST_WAIT:   if (core_done_all) state_d = ST_NEXT;
            ST_NEXT:   state_d = grid_last ? ST_FINISH : ST_LOAD;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            x0_q         <= '0;
            y0_q         <= '0;
            w_m1_q       <= '0;
            h_m1_q       <= '0;
            core_cpmv_0  <= '0;
            core_cpmv_1  <= '0;
            core_coord_x <= '0;
            core_coord_y <= '0;
        end else begin
            if (accept) begin
                x0_q        <= req_x0;
                y0_q        <= req_y0;
                w_m1_q      <= req_w_m1;
                h_m1_q      <= req_h_m1;
                core_cpmv_0 <= req_cpmv_0;
                core_cpmv_1 <= req_cpmv_1;
            end
            // Coordinates wrap modulo 256 by truncation to COORD_W.
            if (state_q == ST_LOAD) begin
                core_coord_x <= x0_q + COORD_W'(BLK_STEP) * COORD_W'(col);
                core_coord_y <= y0_q + COORD_W'(BLK_STEP) * COORD_W'(row);
            end
        end
    end

`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            perf_cycles <= '0;
        end else if (accept) begin
            perf_cycles <= PERF_W'(1);
        end else if (state_q != ST_IDLE && perf_cycles != '1) begin
            perf_cycles <= perf_cycles + 1'b1;
        end
    end
`endif

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign core_start = (state_q == ST_START);
    assign cu_done    = (state_q == ST_FINISH);
    assign sb_idx     = {row, col};
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_affine_subblock_scheduler.sv
// Randomized self-checking bench for affine_subblock_scheduler against a raster-walk model.
module tb_affine_subblock_scheduler;

    logic        clk = 1'b0;
    logic        rst_async_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_x0, req_y0;
    logic [3:0]  req_w_m1, req_h_m1;
    logic [15:0] req_cpmv_0, req_cpmv_1;
    logic        core_start;
    logic [7:0]  core_coord_x, core_coord_y;
    logic [15:0] core_cpmv_0, core_cpmv_1;
    logic        core_done_all;
    logic        busy;
    logic        cu_done;
    logic [7:0]  sb_idx;
    logic [2:0]  dbg_state;
`ifdef SCHED_PERF_CNT_EN
    logic [15:0] perf_cycles;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    bit scramble = 1'b0;

    always #5 clk = ~clk;

    affine_subblock_scheduler dut (
        .clk          (clk),
        .rst_async_n  (rst_async_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x0       (req_x0),
        .req_y0       (req_y0),
        .req_w_m1     (req_w_m1),
        .req_h_m1     (req_h_m1),
        .req_cpmv_0   (req_cpmv_0),
        .req_cpmv_1   (req_cpmv_1),
        .core_start   (core_start),
        .core_coord_x (core_coord_x),
        .core_coord_y (core_coord_y),
        .core_cpmv_0  (core_cpmv_0),
        .core_cpmv_1  (core_cpmv_1),
        .core_done_all(core_done_all),
        .busy         (busy),
        .cu_done      (cu_done),
`ifdef SCHED_PERF_CNT_EN
        .perf_cycles  (perf_cycles),
`endif
        .sb_idx       (sb_idx),
        .dbg_state    (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (scramble) begin
            req_x0     = 8'($urandom);
            req_y0     = 8'($urandom);
            req_w_m1   = 4'($urandom);
            req_h_m1   = 4'($urandom);
            req_cpmv_0 = 16'($urandom);
            req_cpmv_1 = 16'($urandom);
        end
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!core_start && n < 20);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_start"}, 32'(core_start), 32'd0);
        check({tag, "_cx"},    32'(core_coord_x), 32'd0);
        check({tag, "_cy"},    32'(core_coord_y), 32'd0);
        check({tag, "_mv0"},   32'(core_cpmv_0), 32'd0);
        check({tag, "_mv1"},   32'(core_cpmv_1), 32'd0);
        check({tag, "_done"},  32'(cu_done), 32'd0);
        check({tag, "_idx"},   32'(sb_idx), 32'd0);
    endtask

    // Called at an IDLE negedge, or at the FINISH negedge of the previous CU when chained.
    // Returns at the FINISH negedge of this CU.
    task automatic run_cu(input logic [7:0] x0, input logic [7:0] y0,
                          input logic [3:0] w, input logic [3:0] h,
                          input logic [15:0] c0, input logic [15:0] c1,
                          input int lat_fix, input bit chained, input bit hold,
                          input bit spurious, input bit keep_valid);
        int n;
        int lat;
        logic [31:0] e;
        exp_q.delete();
        for (int r = 0; r <= int'(h); r++)
            for (int c = 0; c <= int'(w); c++)
                exp_q.push_back({8'(r * 16 + c), 8'((int'(x0) + 4 * c) % 256),
                                 8'((int'(y0) + 4 * r) % 256), 8'h00});
        scramble   = 1'b0;
        req_x0     = x0;
        req_y0     = y0;
        req_w_m1   = w;
        req_h_m1   = h;
        req_cpmv_0 = c0;
        req_cpmv_1 = c1;
        req_valid  = 1'b1;
        if (chained) begin
            tick();
            check("chain_done_low", 32'(cu_done), 32'd0);
        end
        check("accept_ready", 32'(req_ready), 32'd1);
        check("accept_busy", 32'(busy), 32'd0);
        if (spurious) core_done_all = 1'b1;
        tick();
        if (!hold) req_valid = 1'b0;
        scramble = hold;
        check("load_ready", 32'(req_ready), 32'd0);
        check("load_busy", 32'(busy), 32'd1);
        check("load_start", 32'(core_start), 32'd0);
        wait_start(n);
        check("first_start_lat", 32'(n), 32'd1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("start_seen", 32'(core_start), 32'd1);
            if (!core_start) begin
                core_done_all = 1'b0;
                exp_q.delete();
                break;
            end
            core_done_all = 1'b0;
            check("coord_x", 32'(core_coord_x), 32'(e[23:16]));
            check("coord_y", 32'(core_coord_y), 32'(e[15:8]));
            check("sb_idx", 32'(sb_idx), 32'(e[31:24]));
            check("cpmv_0", 32'(core_cpmv_0), 32'(c0));
            check("cpmv_1", 32'(core_cpmv_1), 32'(c1));
            lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(6, 1));
            for (int k = 0; k < lat; k++) begin
                tick();
                check("wait_start_low", 32'(core_start), 32'd0);
                check("wait_hold_x", 32'(core_coord_x), 32'(e[23:16]));
                check("wait_ready_low", 32'(req_ready), 32'd0);
                check("wait_no_done", 32'(cu_done), 32'd0);
            end
            core_done_all = 1'b1;
            tick();
            core_done_all = 1'b0;
            check("next_done_low", 32'(cu_done), 32'd0);
            check("next_busy", 32'(busy), 32'd1);
            if (exp_q.size() > 0) begin
                wait_start(n);
                check("next_start_lat", 32'(n), 32'd2);
            end else begin
                tick();
                check("cu_done", 32'(cu_done), 32'd1);
                check("finish_busy", 32'(busy), 32'd1);
                check("finish_mv0", 32'(core_cpmv_0), 32'(c0));
            end
        end
        scramble = 1'b0;
        if (!keep_valid) req_valid = 1'b0;
    endtask

    task automatic idle_after();
        tick();
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done_low", 32'(cu_done), 32'd0);
    endtask

    initial begin
        bit prev_keep;
        bit keep;
        bit hold;
        rst_async_n   = 1'b0;
        req_valid     = 1'b0;
        req_x0        = '0;
        req_y0        = '0;
        req_w_m1      = '0;
        req_h_m1      = '0;
        req_cpmv_0    = '0;
        req_cpmv_1    = '0;
        core_done_all = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_async_n = 1'b1;
        tick();
        check("post_reset_state", 32'(dbg_state), 32'd0);

        run_cu(8'd16, 8'd8, 4'd0, 4'd0, 16'h1234, 16'hbeef, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_after();
        run_cu(8'd0, 8'd0, 4'd1, 4'd1, 16'h0a0a, 16'h5050, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_after();
        run_cu(8'd252, 8'd30, 4'd1, 4'd0, 16'h7777, 16'h8888, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_after();
        run_cu(8'd40, 8'd250, 4'd2, 4'd1, 16'hcafe, 16'hf00d, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_after();
        run_cu(8'd100, 8'd60, 4'd1, 4'd0, 16'h1111, 16'h2222, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        run_cu(8'd200, 8'd10, 4'd0, 4'd1, 16'h3333, 16'h4444, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_after();

        prev_keep = 1'b0;
        for (int t = 0; t < 10; t++) begin
            hold = ($urandom_range(1, 0) == 1);
            keep = (t < 9) && ($urandom_range(1, 0) == 1);
            run_cu(8'($urandom), 8'($urandom), 4'($urandom_range(3, 0)), 4'($urandom_range(3, 0)),
                   16'($urandom), 16'($urandom), 0, prev_keep, hold,
                   ($urandom_range(1, 0) == 1), keep);
            if (!keep) idle_after();
            prev_keep = keep;
        end

        // Reset pulsed while the scheduler waits on the core.
        req_x0     = 8'd77;
        req_y0     = 8'd99;
        req_w_m1   = 4'd2;
        req_h_m1   = 4'd2;
        req_cpmv_0 = 16'habcd;
        req_cpmv_1 = 16'h4321;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        check("pre_reset_wait", 32'(busy), 32'd1);
        #2 rst_async_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_async_n = 1'b1;
        tick();
        check("reset_release_ready", 32'(req_ready), 32'd1);
        run_cu(8'd5, 8'd6, 4'd1, 4'd1, 16'h0f0f, 16'hf0f0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_after();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
